// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the data-memory responder: FSM states,
// byte-lane width and the lane mask / extraction functions.
package data_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Bits of the byte address that select a lane inside a 32-bit word.
  localparam int LANE_W = 2;

  // Byte-write mask: all four lanes for a word access, one lane for a byte access.
  function automatic logic [3:0] lane_mask(input logic is_byte, input logic [LANE_W-1:0] lane);
    if (!is_byte) begin
      return 4'hF;
    end
    return 4'b0001 << lane;
  endfunction

  // Load result: the full word, or the addressed lane zero-extended.
  function automatic logic [31:0] lane_extract(input logic is_byte, input logic [LANE_W-1:0] lane,
                                               input logic [31:0] word);
    if (!is_byte) begin
      return word;
    end
    return {24'd0, word[8*lane +: 8]};
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response channel between the execute stage (master) and the
// data-memory responder (slave).
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_byte;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_byte, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_byte, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_mem_array.sv
// Single-port word array built as four independent byte lanes, each with its
// own write enable and a registered (read-before-write) output.
module data_mem_array #(
  parameter int DEPTH_WORDS = 1024,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          i_en,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] r_mem [DEPTH_WORDS];
      logic [7:0] r_rdata;

      // One byte lane: masked write and registered read on the same port.
      always_ff @(posedge clk) begin
        if (i_en) begin
          if (i_we && i_be[gi]) begin
            r_mem[i_addr] <= i_wdata[8*gi +: 8];
          end
          r_rdata <= r_mem[i_addr];
        end
      end

      assign o_rdata[8*gi +: 8] = r_rdata;
    end
  endgenerate

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits WAIT_STATES
// cycles, commits the access to the word array on the edge entering RESP and
// presents a one-cycle response carrying load data and an error flag.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_responder_if.slave  bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_ready;
  logic        r_resp_valid;
  logic        r_err;
  logic        r_write;
  logic        r_byte;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  logic        w_enter_resp;
  logic        w_commit;
  logic        w_eff_write;
  logic        w_eff_byte;
  logic [31:0] w_eff_addr;
  logic [31:0] w_eff_wdata;
  logic        w_misaligned;
  logic        w_out_of_range;
  logic        w_err;
  logic [31:0] w_rd_word;

  // With zero wait states the commit edge is the accept edge itself, so the
  // access must use the live request; otherwise it uses the latched copy.
  assign w_eff_write = (r_state == ST_IDLE) ? bus.req_write : r_write;
  assign w_eff_byte  = (r_state == ST_IDLE) ? bus.req_byte  : r_byte;
  assign w_eff_addr  = (r_state == ST_IDLE) ? bus.req_addr  : r_addr;
  assign w_eff_wdata = (r_state == ST_IDLE) ? bus.req_wdata : r_wdata;

  assign w_misaligned   = !w_eff_byte && (w_eff_addr[1:0] != 2'b00);
  assign w_out_of_range = (w_eff_addr >> (AW + 2)) != 32'd0;
  assign w_err          = w_misaligned || w_out_of_range;

  assign w_enter_resp = (WAIT_STATES == 0) ? ((r_state == ST_IDLE) && bus.req_valid)
                                           : ((r_state == ST_BUSY) && (r_cnt == 4'd0));

  // Reset gates the commit so an in-flight store (or a request presented
  // while reset is held) can never reach the array.
  assign w_commit = w_enter_resp && !rst;

  data_mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk     (clk),
    .i_en    (w_commit && !w_err),
    .i_we    (w_eff_write),
    .i_be    (lane_mask(w_eff_byte, w_eff_addr[LANE_W-1:0])),
    .i_addr  (w_eff_addr[AW+1:2]),
    .i_wdata (w_eff_byte ? {4{w_eff_wdata[7:0]}} : w_eff_wdata),
    .o_rdata (w_rd_word)
  );

  // Request FSM with registered handshake outputs and latched request fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 4'd0;
      r_ready      <= 1'b1;
      r_resp_valid <= 1'b0;
      r_err        <= 1'b0;
      r_write      <= 1'b0;
      r_byte       <= 1'b0;
      r_addr       <= 32'd0;
      r_wdata      <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            r_write <= bus.req_write;
            r_byte  <= bus.req_byte;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
            r_ready <= 1'b0;
            if (WAIT_STATES == 0) begin
              r_state      <= ST_RESP;
              r_resp_valid <= 1'b1;
              r_err        <= w_err;
            end else begin
              r_state <= ST_BUSY;
              r_cnt   <= CNT_INIT;
            end
          end
        end
        ST_BUSY: begin
          if (r_cnt == 4'd0) begin
            r_state      <= ST_RESP;
            r_resp_valid <= 1'b1;
            r_err        <= w_err;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          r_state      <= ST_IDLE;
          r_ready      <= 1'b1;
          r_resp_valid <= 1'b0;
          r_err        <= 1'b0;
        end
        default: begin
          r_state      <= ST_IDLE;
          r_ready      <= 1'b1;
          r_resp_valid <= 1'b0;
          r_err        <= 1'b0;
        end
      endcase
    end
  end

  // Response data exists only for a successful load during the RESP cycle;
  // the array word was registered on the edge that entered RESP.
  assign bus.req_ready  = r_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_err   = r_resp_valid && r_err;
  assign bus.resp_rdata = (r_resp_valid && !r_err && !r_write)
                        ? lane_extract(r_byte, r_addr[LANE_W-1:0], w_rd_word)
                        : 32'd0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: one DUT with two wait states, one with none, each
// checked against a word-array reference model driven by the same requests.
module tb_data_mem_responder;

  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_mem_responder_if ifa();
  data_mem_responder_if ifb();

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(2)) dut_a (
    .clk (clk), .rst (rst), .bus (ifa.slave)
  );
  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut_b (
    .clk (clk), .rst (rst), .bus (ifb.slave)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] model_a [int];
  logic [31:0] model_b [int];

  task automatic drive(input int sel, input logic v, input logic w, input logic b,
                       input logic [31:0] a, input logic [31:0] d);
    if (sel == 0) begin
      ifa.req_valid = v; ifa.req_write = w; ifa.req_byte = b; ifa.req_addr = a; ifa.req_wdata = d;
    end else begin
      ifb.req_valid = v; ifb.req_write = w; ifb.req_byte = b; ifb.req_addr = a; ifb.req_wdata = d;
    end
  endtask

  function automatic logic rdy(input int sel);
    return (sel == 0) ? ifa.req_ready : ifb.req_ready;
  endfunction
  function automatic logic rv(input int sel);
    return (sel == 0) ? ifa.resp_valid : ifb.resp_valid;
  endfunction
  function automatic logic [31:0] rdat(input int sel);
    return (sel == 0) ? ifa.resp_rdata : ifb.resp_rdata;
  endfunction
  function automatic logic rerr(input int sel);
    return (sel == 0) ? ifa.resp_err : ifb.resp_err;
  endfunction

  // Reference model: a plain word array indexed by addr/4, with lanes handled
  // by shifting and masking.
  task automatic model_op(input int sel, input logic w, input logic b, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] erd, output logic eerr);
    int idx;
    int sh;
    logic [31:0] word;
    eerr = (!b && (a % 4 != 0)) || (a >= 32'(4 * DEPTH));
    erd  = 32'd0;
    if (eerr) return;
    idx = int'(a / 4);
    sh  = int'(a % 4) * 8;
    if (sel == 0) word = model_a.exists(idx) ? model_a[idx] : 32'd0;
    else          word = model_b.exists(idx) ? model_b[idx] : 32'd0;
    if (w) begin
      if (b) word = (word & ~(32'hFF << sh)) | ({24'd0, d[7:0]} << sh);
      else   word = d;
      if (sel == 0) model_a[idx] = word;
      else          model_b[idx] = word;
    end else begin
      erd = b ? ((word >> sh) & 32'hFF) : word;
    end
  endtask

  // One request: wait for ready, hold until accepted, then wait for the
  // response. lat counts cycles from the accept edge to the response cycle.
  task automatic txn(input int sel, input logic w, input logic b, input logic [31:0] a,
                     input logic [31:0] d, output logic [31:0] rd, output logic er,
                     output int lat, output logic busy_ok);
    int n;
    busy_ok = 1'b1; lat = -1; rd = 32'd0; er = 1'b0;
    @(negedge clk);
    drive(sel, 1'b1, w, b, a, d);
    n = 0;
    while (!rdy(sel) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rdy(sel)) begin
      checks++; errors++;
      $display("FAIL accept_timeout dut=%0d addr=%h: ready got 0 required 1", sel, a);
      drive(sel, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      return;
    end
    @(posedge clk);
    #1 drive(sel, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (rdy(sel)) busy_ok = 1'b0;
      if (rv(sel)) begin
        lat = k; rd = rdat(sel); er = rerr(sel);
        break;
      end
    end
    if (lat < 0) begin
      checks++; errors++;
      $display("FAIL resp_timeout dut=%0d addr=%h: resp_valid got 0 required 1", sel, a);
    end
    $display("txn dut=%0d w=%0b b=%0b addr=%h wdata=%h rdata=%h err=%0b lat=%0d",
             sel, w, b, a, d, rd, er, lat);
  endtask

  // Runs a request on a DUT and compares it against the model.
  task automatic run_checked(input string name, input int sel, input logic w, input logic b,
                             input logic [31:0] a, input logic [31:0] d, input int exp_lat);
    logic [31:0] rd, erd;
    logic er, eerr, busy_ok;
    int lat;
    model_op(sel, w, b, a, d, erd, eerr);
    txn(sel, w, b, a, d, rd, er, lat, busy_ok);
    checks++;
    if (er !== eerr) begin
      errors++;
      $display("FAIL %s.err addr=%h: got %0b required %0b", name, a, er, eerr);
    end
    if (!w || eerr) begin
      checks++;
      if (rd !== erd) begin
        errors++;
        $display("FAIL %s.rdata addr=%h: got %h required %h", name, a, rd, erd);
      end
    end
    checks++;
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL %s.latency addr=%h: got %0d required %0d", name, a, lat, exp_lat);
    end
    checks++;
    if (!busy_ok) begin
      errors++;
      $display("FAIL %s.ready_low addr=%h: got ready=1 while busy required 0", name, a);
    end
  endtask

  task automatic test_reset;
    drive(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks += 5;
    if (ifa.req_ready !== 1'b1) begin errors++; $display("FAIL reset.ready_a: got %b required 1", ifa.req_ready); end
    if (ifa.resp_valid !== 1'b0) begin errors++; $display("FAIL reset.resp_valid_a: got %b required 0", ifa.resp_valid); end
    if (ifa.resp_rdata !== 32'd0) begin errors++; $display("FAIL reset.rdata_a: got %h required 0", ifa.resp_rdata); end
    if (ifa.resp_err !== 1'b0) begin errors++; $display("FAIL reset.err_a: got %b required 0", ifa.resp_err); end
    if (ifb.req_ready !== 1'b1) begin errors++; $display("FAIL reset.ready_b: got %b required 1", ifb.req_ready); end
    rst = 1'b0;
  endtask

  task automatic test_word;
    run_checked("word_store", 0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 3);
    @(negedge clk);
    checks += 2;
    if (ifa.resp_valid !== 1'b0) begin errors++; $display("FAIL word.pulse_width: got %b required 0", ifa.resp_valid); end
    if (ifa.req_ready !== 1'b1) begin errors++; $display("FAIL word.ready_after: got %b required 1", ifa.req_ready); end
    run_checked("word_load", 0, 1'b0, 1'b0, 32'h10, 32'h0, 3);
  endtask

  task automatic test_byte;
    run_checked("byte_store", 0, 1'b1, 1'b1, 32'h11, 32'hFFFFFF5A, 3);
    run_checked("byte_merge_load", 0, 1'b0, 1'b0, 32'h10, 32'h0, 3);
    run_checked("byte_load_lane3", 0, 1'b0, 1'b1, 32'h13, 32'h0, 3);
    run_checked("byte_load_lane0", 0, 1'b0, 1'b1, 32'h10, 32'h0, 3);
  endtask

  task automatic test_errors;
    run_checked("err_setup", 0, 1'b1, 1'b0, 32'h20, 32'h11223344, 3);
    run_checked("err_misaligned_load", 0, 1'b0, 1'b0, 32'h12, 32'h0, 3);
    run_checked("err_misaligned_store", 0, 1'b1, 1'b0, 32'h21, 32'hA5A5A5A5, 3);
    run_checked("err_reread", 0, 1'b0, 1'b0, 32'h20, 32'h0, 3);
    run_checked("err_oor_load", 0, 1'b0, 1'b0, 32'(4 * DEPTH), 32'h0, 3);
    run_checked("err_oor_byte", 0, 1'b0, 1'b1, 32'(4 * DEPTH + 3), 32'h0, 3);
    run_checked("last_word_store", 0, 1'b1, 1'b0, 32'(4 * DEPTH - 4), 32'h8899AABB, 3);
    run_checked("last_byte_load", 0, 1'b0, 1'b1, 32'(4 * DEPTH - 1), 32'h0, 3);
  endtask

  task automatic test_back_to_back;
    logic [31:0] dat [5];
    int acc_cyc [5];
    int idx;
    int last_acc;
    logic [31:0] erd;
    logic eerr;
    for (int i = 0; i < 5; i++) dat[i] = $urandom;
    idx = 0;
    last_acc = -10;
    @(negedge clk);
    drive(1, 1'b1, 1'b1, 1'b0, 32'h200, dat[0]);
    for (int c = 0; c < 11; c++) begin
      checks++;
      if (rv(1) !== (last_acc == c - 1)) begin
        errors++;
        $display("FAIL b2b.resp_valid cycle=%0d: got %b required %b", c, rv(1), (last_acc == c - 1));
      end
      if (rdy(1) && idx < 5) begin
        acc_cyc[idx] = c;
        last_acc = c;
        model_op(1, 1'b1, 1'b0, 32'h200 + 32'(4 * idx), dat[idx], erd, eerr);
        $display("txn dut=1 w=1 b=0 addr=%h wdata=%h accepted cycle=%0d", 32'h200 + 32'(4 * idx), dat[idx], c);
        idx++;
      end
      @(posedge clk);
      #1;
      if (idx < 5) drive(1, 1'b1, 1'b1, 1'b0, 32'h200 + 32'(4 * idx), dat[idx]);
      else         drive(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      @(negedge clk);
    end
    checks++;
    if (idx != 5) begin
      errors++;
      $display("FAIL b2b.accept_count: got %0d required 5", idx);
    end else begin
      for (int i = 1; i < 5; i++) begin
        checks++;
        if (acc_cyc[i] - acc_cyc[i-1] != 2) begin
          errors++;
          $display("FAIL b2b.spacing idx=%0d: got %0d required 2", i, acc_cyc[i] - acc_cyc[i-1]);
        end
      end
    end
    for (int i = 0; i < 5; i++) run_checked("b2b_readback", 1, 1'b0, 1'b0, 32'h200 + 32'(4 * i), 32'h0, 1);
  endtask

  task automatic test_reset_busy;
    run_checked("rb_setup", 0, 1'b1, 1'b0, 32'h40, 32'hCAFEF00D, 3);
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 1'b0, 32'h40, 32'h12345678);
    @(posedge clk);
    #1 drive(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    checks++;
    if (ifa.req_ready !== 1'b0) begin errors++; $display("FAIL rb.busy_ready: got %b required 0", ifa.req_ready); end
    rst = 1'b1;
    #1;
    checks += 2;
    if (ifa.req_ready !== 1'b1) begin errors++; $display("FAIL rb.ready_on_reset: got %b required 1", ifa.req_ready); end
    if (ifa.resp_valid !== 1'b0) begin errors++; $display("FAIL rb.resp_on_reset: got %b required 0", ifa.resp_valid); end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (ifa.resp_valid !== 1'b0) begin errors++; $display("FAIL rb.no_pulse k=%0d: got %b required 0", k, ifa.resp_valid); end
    end
    run_checked("rb_readback", 0, 1'b0, 1'b0, 32'h40, 32'h0, 3);
  endtask

  task automatic test_random;
    logic w, b;
    logic [31:0] a, d;
    for (int i = 0; i < 16; i++) run_checked("rnd_fill", 0, 1'b1, 1'b0, 32'h100 + 32'(4 * i), $urandom, 3);
    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      a = 32'h100 + 32'($urandom_range(0, 63));
      if (!b && $urandom_range(0, 9) < 8) a = a & ~32'h3;
      if ($urandom_range(0, 19) == 0) a = 32'(4 * DEPTH) + 32'($urandom_range(0, 255));
      d = $urandom;
      run_checked("rnd", 0, w, b, a, d, 3);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_errors();
    test_back_to_back();
    test_reset_busy();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation time got 500000 required less");
    $fatal(1, "timeout");
  end

endmodule
